// File: rtl/ex_mem_pipe.sv
// Execute-to-memory pipeline register with the Z/V/N flag register, stall/flush and sticky halt.
// Optional build macro: EX_FLAG_BYPASS_EN drives flag_* from the combinational next-state.
module ex_mem_pipe #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_ovfl,
  input  logic [3:0]    ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_halt,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_halt,
  output logic [DW-1:0] mem_alu_out,
  output logic [DW-1:0] mem_store_data,
  output logic [3:0]    mem_rd,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic load_s;
  logic flag_z_r, flag_v_r, flag_n_r;
  logic flag_z_s, flag_v_s, flag_n_s;

  assign load_s = !halted && !flush && !stall;

  // Next-state flags: only a valid loaded instruction of a flag-setting class changes them.
  always_comb begin
    flag_z_s = flag_z_r;
    flag_v_s = flag_v_r;
    flag_n_s = flag_n_r;
    if (load_s && ex_valid) begin
      case (ex_opcode)
        OP_ADD, OP_SUB: begin
          flag_z_s = (ex_alu_out == {DW{1'b0}});
          flag_v_s = ex_ovfl;
          flag_n_s = ex_alu_out[DW-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          flag_z_s = (ex_alu_out == {DW{1'b0}});
        end
        default: begin
          flag_z_s = flag_z_r;
        end
      endcase
    end else begin
      flag_z_s = flag_z_r;
    end
  end

  // Flag register; next-state already folds in hold conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_r <= 1'b0;
      flag_v_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else begin
      flag_z_r <= flag_z_s;
      flag_v_r <= flag_v_s;
      flag_n_r <= flag_n_s;
    end
  end

  // Pipeline register: halted freezes everything, flush bubbles control, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_halt       <= 1'b0;
      mem_alu_out    <= {DW{1'b0}};
      mem_store_data <= {DW{1'b0}};
      mem_rd         <= 4'h0;
      halted         <= 1'b0;
    end else if (halted) begin
      halted <= 1'b1;
    end else if (flush) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_halt      <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_reg_write  <= ex_valid & ex_reg_write;
      mem_mem_read   <= ex_valid & ex_mem_read;
      mem_mem_write  <= ex_valid & ex_mem_write;
      mem_halt       <= ex_valid & ex_halt;
      mem_alu_out    <= ex_alu_out;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      halted         <= ex_valid & ex_halt;
    end
  end

`ifdef EX_FLAG_BYPASS_EN
  assign flag_z = flag_z_s;
  assign flag_v = flag_v_s;
  assign flag_n = flag_n_s;
`else
  assign flag_z = flag_z_r;
  assign flag_v = flag_v_r;
  assign flag_n = flag_n_r;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: behavioural model checked every negedge plus literal spot checks.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = 4'h0;
  logic [15:0] ex_alu_out = 16'h0000;
  logic        ex_ovfl = 1'b0;
  logic [3:0]  ex_rd = 4'h0;
  logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_halt = 1'b0;
  logic [15:0] ex_store_data = 16'h0000;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
  logic [15:0] mem_alu_out, mem_store_data;
  logic [3:0]  mem_rd;
  logic        flag_z, flag_v, flag_n, halted;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_valid, m_rw, m_mr, m_mw, m_halt, m_halted, m_z, m_v, m_n;
  logic [15:0] m_alu, m_sd;
  logic [3:0]  m_rd;

  ex_mem_pipe #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out), .ex_ovfl(ex_ovfl), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_halt(ex_halt), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_halt(mem_halt), .mem_alu_out(mem_alu_out),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Which flags an opcode class writes: {z, v, n}
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3'b111;
    else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
    else return 3'b000;
  endfunction

  // Model update per edge: reset > halted > flush > stall > load
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_halt <= 1'b0;
      m_halted <= 1'b0; m_z <= 1'b0; m_v <= 1'b0; m_n <= 1'b0;
      m_alu <= 16'h0000; m_sd <= 16'h0000; m_rd <= 4'h0;
    end else if (!m_halted) begin
      if (flush) begin
        m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_halt <= 1'b0;
      end else if (!stall) begin
        m_valid <= ex_valid;
        m_rw <= ex_valid && ex_reg_write;
        m_mr <= ex_valid && ex_mem_read;
        m_mw <= ex_valid && ex_mem_write;
        m_halt <= ex_valid && ex_halt;
        m_halted <= ex_valid && ex_halt;
        m_alu <= ex_alu_out; m_sd <= ex_store_data; m_rd <= ex_rd;
        if (ex_valid && flag_mask(ex_opcode)[2]) m_z <= (ex_alu_out == 16'h0000);
        if (ex_valid && flag_mask(ex_opcode)[1]) m_v <= ex_ovfl;
        if (ex_valid && flag_mask(ex_opcode)[0]) m_n <= ex_alu_out[15];
      end
    end
  end

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    logic ez, ev, en, ld;
    ez = m_z; ev = m_v; en = m_n;
`ifdef EX_FLAG_BYPASS_EN
    ld = rst_n && !m_halted && !flush && !stall && ex_valid;
    if (ld && flag_mask(ex_opcode)[2]) ez = (ex_alu_out == 16'h0000);
    if (ld && flag_mask(ex_opcode)[1]) ev = ex_ovfl;
    if (ld && flag_mask(ex_opcode)[0]) en = ex_alu_out[15];
`else
    ld = 1'b0;
`endif
    check("mdl_valid", {15'h0, mem_valid}, {15'h0, m_valid});
    check("mdl_reg_write", {15'h0, mem_reg_write}, {15'h0, m_rw});
    check("mdl_mem_read", {15'h0, mem_mem_read}, {15'h0, m_mr});
    check("mdl_mem_write", {15'h0, mem_mem_write}, {15'h0, m_mw});
    check("mdl_mem_halt", {15'h0, mem_halt}, {15'h0, m_halt});
    check("mdl_halted", {15'h0, halted}, {15'h0, m_halted});
    check("mdl_alu_out", mem_alu_out, m_alu);
    check("mdl_store_data", mem_store_data, m_sd);
    check("mdl_rd", {12'h0, mem_rd}, {12'h0, m_rd});
    check("mdl_flags", {13'h0, flag_z, flag_v, flag_n}, {13'h0, ez, ev, en});
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu, input logic ov,
                       input logic [3:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic hl, input logic [15:0] sd);
    ex_valid = v; ex_opcode = op; ex_alu_out = alu; ex_ovfl = ov; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_halt = hl; ex_store_data = sd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flags_are(input string name, input logic [2:0] exp);
    check(name, {13'h0, flag_z, flag_v, flag_n}, {13'h0, exp});
  endtask

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    check("reset_outputs", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt,
                            halted, flag_z, flag_v, flag_n, 7'h00}, 16'h0000);
    check("reset_alu", mem_alu_out, 16'h0000);

    // ADD zero result with overflow
    drive(1'b1, 4'h0, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234); cyc();
    flags_are("add_flags", 3'b110);
    check("add_alu", mem_alu_out, 16'h0000);
    check("add_valid", {15'h0, mem_valid}, 16'h0001);

    // RED leaves flags, XOR updates Z only
    drive(1'b1, 4'h3, 16'hFFC0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); cyc();
    check("red_alu", mem_alu_out, 16'hFFC0);
    flags_are("red_flags", 3'b110);
    drive(1'b1, 4'h2, 16'h8001, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); cyc();
    flags_are("xor_flags", 3'b010);

    // Stall three cycles with changing inputs
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'h0, 16'h1111 * i[15:0], 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD); cyc();
      check("stall_alu", mem_alu_out, 16'h8001);
      check("stall_rd", {12'h0, mem_rd}, 16'h0005);
      flags_are("stall_flags", 3'b010);
    end
    flush = 1'b1; cyc();
    check("flush_valid_rw", {14'h0, mem_valid, mem_reg_write}, 16'h0000);
    check("flush_keeps_data", mem_alu_out, 16'h8001);
    stall = 1'b0; flush = 1'b0;

    // Invalid SUB never writes or touches flags
    drive(1'b0, 4'h1, 16'h0000, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555); cyc();
    check("inv_ctrl", {11'h0, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt}, 16'h0000);
    flags_are("inv_flags", 3'b010);
    check("inv_halted", {15'h0, halted}, 16'h0000);

    // Store, shift and PADDSB traffic
    drive(1'b1, 4'h4, 16'h0000, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF); cyc();
    check("sw_ctrl", {13'h0, mem_mem_read, mem_mem_write, mem_reg_write}, 16'h0002);
    check("sw_data", mem_store_data, 16'hBEEF);
    flags_are("sll_flags", 3'b110);
    drive(1'b1, 4'h7, 16'h0000, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); cyc();
    flags_are("paddsb_flags", 3'b110);

    // SUB negative: bypass build shows N before the edge
    drive(1'b1, 4'h1, 16'h8000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
`ifdef EX_FLAG_BYPASS_EN
    flags_are("sub_bypass_flags", 3'b001);
`else
    flags_are("sub_pre_flags", 3'b110);
`endif
    cyc();
    flags_are("sub_flags", 3'b001);

    // Halt capture and freeze
    drive(1'b1, 4'hF, 16'h00AA, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); cyc();
    check("hlt_state", {14'h0, halted, mem_halt}, 16'h0003);
    drive(1'b1, 4'h0, 16'h0005, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); cyc();
    flush = 1'b1; cyc(); flush = 1'b0; cyc();
    check("hlt_frozen_alu", mem_alu_out, 16'h00AA);
    check("hlt_frozen_ctrl", {13'h0, halted, mem_halt, mem_valid}, 16'h0007);
    flags_are("hlt_flags", 3'b001);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt,
                          halted, flag_z, flag_v, flag_n, 7'h00}, 16'h0000);
    check("async_reset_alu", mem_alu_out, 16'h0000);
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 4'h0, 16'h0005, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); cyc();
    check("post_reset_alu", mem_alu_out, 16'h0005);
    flags_are("post_reset_flags", 3'b000);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
